cube_loader: RTL and testbench

CUBE_LOADER -- requirements
Module: cube_loader

---
 rtl/cube_loader.sv | 117 +++++++++++
 tb/tb_cube_loader.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/cube_loader.sv
// Byte-stream loader for a cube solver: assembles 15 bytes into a 120-bit state,
// pulses run, then waits for the solver's finish edge or a timeout.
module cube_loader #(
  parameter int unsigned            CNT_W   = 20,
  parameter logic [CNT_W-1:0]       TIMEOUT = 20'hFFFFF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [7:0]       in_data,
  output logic             in_ready,
  output logic [119:0]     d,
  output logic             run,
  input  logic             fin,
  output logic             busy,
  output logic             done,
  output logic             timeout,
  output logic [CNT_W-1:0] cycles
);

  typedef enum logic [1:0] {LOAD, RUN, WAIT} state_e;

  state_e           state_q, state_d;
  logic [3:0]       idx_q, idx_d;
  logic [119:0]     d_q, d_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] cycles_q, cycles_d;
  logic             done_d, to_d;
  logic             fin_q, fin_evt;
  logic             rdy_q, run_q, busy_q, done_q, to_q;
  logic [6:0]       pos;

  assign fin_evt = fin && !fin_q;
  assign pos     = 7'd119 - {idx_q, 3'b000};

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    d_d      = d_q;
    cnt_d    = cnt_q;
    cycles_d = cycles_q;
    done_d   = 1'b0;
    to_d     = 1'b0;
    case (state_q)
      LOAD: begin
        if (in_valid && rdy_q) begin
          d_d[pos -: 8] = in_data;
          if (idx_q == 4'd14) begin
            idx_d   = 4'd0;
            state_d = RUN;
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end
      end
      RUN: begin
        state_d = WAIT;
        cnt_d   = '0;
      end
      WAIT: begin
        cnt_d = cnt_q + 1'b1;
        // Finish takes priority over a timeout landing on the same cycle.
        if (fin_evt) begin
          cycles_d = cnt_q;
          done_d   = 1'b1;
          state_d  = LOAD;
          cnt_d    = '0;
        end else if (cnt_q == TIMEOUT) begin
          cycles_d = TIMEOUT;
          to_d     = 1'b1;
          state_d  = LOAD;
          cnt_d    = '0;
        end
      end
      default: state_d = LOAD;
    endcase
  end

  // Handshake and status flags are registered from the next state, so they
  // line up with the state they describe and never depend on in_valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= LOAD;
      idx_q    <= '0;
      d_q      <= '0;
      cnt_q    <= '0;
      cycles_q <= '0;
      fin_q    <= 1'b0;
      rdy_q    <= 1'b0;
      run_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      to_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      d_q      <= d_d;
      cnt_q    <= cnt_d;
      cycles_q <= cycles_d;
      fin_q    <= fin;
      rdy_q    <= (state_d == LOAD);
      run_q    <= (state_d == RUN);
      busy_q   <= (state_d == RUN) || (state_d == WAIT);
      done_q   <= done_d;
      to_q     <= to_d;
    end
  end

  assign in_ready = rdy_q;
  assign d        = d_q;
  assign run      = run_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign timeout  = to_q;
  assign cycles   = cycles_q;

endmodule

// File: tb/tb_cube_loader.sv
// Self-checking bench for cube_loader: table of solve scenarios with a result
// scoreboard, plus hand-written load, reset and short-timeout sequences.
module tb_cube_loader;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid, fin;
  logic [7:0]   in_data;
  logic         in_ready, run, busy, done, timeout;
  logic [119:0] d;
  logic [19:0]  cycles;

  logic         in_valid5, fin5;
  logic [7:0]   in_data5;
  logic         in_ready5, run5, busy5, done5, timeout5;
  logic [119:0] d5;
  logic [19:0]  cycles5;

  int checks = 0;
  int errors = 0;
  int run_cnt = 0;

  always #5 clk = ~clk;

  cube_loader #(.CNT_W(20), .TIMEOUT(20'd10)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .d(d), .run(run), .fin(fin), .busy(busy),
    .done(done), .timeout(timeout), .cycles(cycles));

  cube_loader #(.CNT_W(20), .TIMEOUT(20'd5)) dut5 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid5), .in_data(in_data5),
    .in_ready(in_ready5), .d(d5), .run(run5), .fin(fin5), .busy(busy5),
    .done(done5), .timeout(timeout5), .cycles(cycles5));

  typedef struct {
    int         fin_at;   // WAIT counter value at which fin rises; -1 = never
    bit         pre;      // fin already high through the load and into WAIT
    bit         e_done;
    bit         e_to;
    logic [19:0] e_cyc;
  } vec_t;

  typedef struct {
    bit          dn;
    bit          to;
    logic [19:0] cyc;
  } res_t;

  res_t sb[$];
  vec_t tbl[6];

  task automatic chk(input string nm, input logic [119:0] act, input logic [119:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Result monitor: every done/timeout pulse must match the oldest expectation.
  always @(negedge clk) begin
    res_t r;
    if (rst_n) begin
      if (run) run_cnt++;
      if (done || timeout) begin
        chk("done_and_timeout", {119'd0, done && timeout}, 120'd0);
        if (sb.size() == 0) begin
          chk("unexpected_result", {118'd0, done, timeout}, 120'd0);
        end else begin
          r = sb.pop_front();
          chk("done", {119'd0, done}, {119'd0, r.dn});
          chk("timeout", {119'd0, timeout}, {119'd0, r.to});
          chk("cycles", {100'd0, cycles}, {100'd0, r.cyc});
          chk("busy_after", {119'd0, busy}, 120'd0);
          chk("ready_after", {119'd0, in_ready}, 120'd1);
        end
      end
    end
  end

  task automatic load_main(input bit gaps, input bit pre);
    logic [119:0] e = '0;
    logic [7:0]   b;
    int           n;
    for (int k = 0; k < 15; k++) begin
      if (gaps && $urandom_range(0, 1) == 1) begin
        in_valid = 1'b0;
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
      b = 8'($urandom);
      in_valid = 1'b1;
      in_data  = b;
      e = {e[111:0], b};
      // A fin edge while loading must be ignored.
      if (!pre && k == 3) fin = 1'b1;
      if (!pre && k == 5) fin = 1'b0;
      n = 0;
      while (!in_ready && n < 50) begin
        @(posedge clk); #1;
        n++;
      end
      if (!in_ready) chk("ready_wait_expired", {119'd0, in_ready}, 120'd1);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    chk("run_pulse", {119'd0, run}, 120'd1);
    chk("d_loaded", d, e);
    chk("busy_run", {119'd0, busy}, 120'd1);
    chk("ready_run", {119'd0, in_ready}, 120'd0);
  endtask

  task automatic run_row(input vec_t v, input bit gaps);
    res_t r;
    int   n;
    r.dn = v.e_done; r.to = v.e_to; r.cyc = v.e_cyc;
    sb.push_back(r);
    fin = v.pre;
    load_main(gaps, v.pre);
    @(posedge clk); #1;                       // WAIT, counter = 0
    chk("run_single", {119'd0, run}, 120'd0);
    if (v.fin_at >= 0) begin
      for (int c = 0; c < v.fin_at; c++) begin
        if (v.pre && c == 3) fin = 1'b0;
        @(posedge clk); #1;
      end
      fin = 1'b1;
    end
    n = 0;
    while (sb.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      chk("result_wait_expired", 120'(sb.size()), 120'd0);
      sb.delete();
    end
    @(posedge clk); #1;
    fin = 1'b0;
  endtask

  initial begin
    tbl[0] = '{fin_at: 6,  pre: 1'b0, e_done: 1'b1, e_to: 1'b0, e_cyc: 20'd6};
    tbl[1] = '{fin_at: -1, pre: 1'b0, e_done: 1'b0, e_to: 1'b1, e_cyc: 20'd10};
    tbl[2] = '{fin_at: 10, pre: 1'b0, e_done: 1'b1, e_to: 1'b0, e_cyc: 20'd10};
    tbl[3] = '{fin_at: 0,  pre: 1'b0, e_done: 1'b1, e_to: 1'b0, e_cyc: 20'd0};
    tbl[4] = '{fin_at: 5,  pre: 1'b1, e_done: 1'b1, e_to: 1'b0, e_cyc: 20'd5};
    tbl[5] = '{fin_at: 9,  pre: 1'b0, e_done: 1'b1, e_to: 1'b0, e_cyc: 20'd9};

    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; fin = 1'b0;
    in_valid5 = 1'b0; in_data5 = '0; fin5 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_d", d, 120'd0);
    chk("rst_ready", {119'd0, in_ready}, 120'd0);
    chk("rst_flags", {116'd0, run, busy, done, timeout}, 120'd0);
    chk("rst_cycles", {100'd0, cycles}, 120'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("ready_after_release", {119'd0, in_ready}, 120'd1);

    // Back-to-back 0x01..0x0F on the short-timeout instance, then fin on counter == TIMEOUT.
    in_valid5 = 1'b1;
    for (int k = 0; k < 15; k++) begin
      in_data5 = 8'(k + 1);
      chk("b2b_ready", {119'd0, in_ready5}, 120'd1);
      @(posedge clk); #1;
    end
    in_valid5 = 1'b0;
    chk("b2b_run", {119'd0, run5}, 120'd1);
    chk("b2b_d", d5, 120'h0102030405060708090A0B0C0D0E0F);
    chk("b2b_ready_low", {119'd0, in_ready5}, 120'd0);
    @(posedge clk); #1;
    chk("b2b_run_once", {119'd0, run5}, 120'd0);
    chk("b2b_busy", {119'd0, busy5}, 120'd1);
    repeat (5) @(posedge clk);
    #1;
    fin5 = 1'b1;
    @(posedge clk); #1;
    chk("t5_done", {119'd0, done5}, 120'd1);
    chk("t5_timeout", {119'd0, timeout5}, 120'd0);
    chk("t5_cycles", {100'd0, cycles5}, 120'd5);
    fin5 = 1'b0;

    for (int i = 0; i < 6; i++) run_row(tbl[i], i[0]);

    // Reset in the middle of a partial load clears everything at once.
    in_valid = 1'b1;
    for (int k = 0; k < 7; k++) begin
      in_data = 8'hA0 + 8'(k);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_d", d, 120'd0);
    chk("mid_rst_ready", {119'd0, in_ready}, 120'd0);
    chk("mid_rst_flags", {116'd0, run, busy, done, timeout}, 120'd0);
    chk("mid_rst_cycles", {100'd0, cycles}, 120'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    run_row(tbl[1], 1'b0);

    chk("run_count", 120'(run_cnt), 120'd7);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
